// File: rtl/cic_integ_decim_pkg.sv
// ---------------------------------------------------------------------------
// cic_integ_pkg
// Shared definitions for the CIC integrator / decimation sampler:
//   - default widths and channel count (dw_def, iw_def, nch_def, pw_def)
//   - sext(): sign-extension rule used to widen input samples
//   - gate_t: valid/keep pair carried alongside the data pipeline
// ---------------------------------------------------------------------------
package cic_integ_pkg;

   localparam int dw_def  = 28;  // integrator / output width
   localparam int iw_def  = 18;  // input sample width
   localparam int nch_def = 4;   // interleaved channels per frame
   localparam int pw_def  = 12;  // width of the decimation ratio

   // Sign-extend the low w bits of v to 64 bits. Callers truncate the result
   // to the integrator width, so dw may be narrower or wider than iw.
   function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
      logic [63:0] sh;
      sh = v << (64 - w);
      return $unsigned($signed(sh) >>> (64 - w));
   endfunction

   // Slot gate travelling one cycle behind the input slot.
   typedef struct packed {
      logic valid;  // slot carried a sample
      logic keep;   // slot belongs to a decimated (emitted) frame
   } gate_t;

endpackage

// File: rtl/cic_integ_decim_if.sv
// ---------------------------------------------------------------------------
// cic_integ_decim_if
// Sample-stream bundle between the upstream source and cic_integ_decim.
//   d_in      [iw]  sample for the current slot
//   g_in            slot valid
//   ch_first        marks channel 0 of a frame (qualified by g_in)
//   period    [pw]  decimation ratio R (0 behaves as 1)
//   d_out     [dw]  double-integrated value of the gated slot
//   g_out           output slot valid
//   frame_err       sticky framing error (only with CIC_INTEG_FRAMECHK_EN)
// Modports: master = stream source / sink, slave = the integrator block.
// ---------------------------------------------------------------------------
interface cic_integ_decim_if
   import cic_integ_pkg::*;
#(
   parameter int dw = dw_def,
   parameter int iw = iw_def,
   parameter int pw = pw_def
) ();

   logic [iw-1:0] d_in;
   logic          g_in;
   logic          ch_first;
   logic [pw-1:0] period;
   logic [dw-1:0] d_out;
   logic          g_out;
`ifdef CIC_INTEG_FRAMECHK_EN
   logic          frame_err;
`endif

   modport master (
      output d_in, g_in, ch_first, period,
`ifdef CIC_INTEG_FRAMECHK_EN
      input  frame_err,
`endif
      input  d_out, g_out
   );

   modport slave (
      input  d_in, g_in, ch_first, period,
`ifdef CIC_INTEG_FRAMECHK_EN
      output frame_err,
`endif
      output d_out, g_out
   );

endinterface

// File: rtl/cic_integ_decim_integ_slot.sv
// ---------------------------------------------------------------------------
// integ_slot
// One time-multiplexed integrator stage: an nch-deep gated delay line whose
// tail re-enters the adder, so each channel's accumulator comes back around
// exactly nch valid slots after it was written.
//   clk, reset_n   clock, asynchronous active-low reset
//   i_adv          advance the line (slot valid for this stage)
//   i_add   [dw]   value added to the returning accumulator
//   o_val   [dw]   tap_sum=0: head register (last written accumulator)
//                  tap_sum=1: new accumulator value (combinational sum)
// ---------------------------------------------------------------------------
module integ_slot #(
   parameter int dw      = 28,
   parameter int nch     = 4,
   parameter bit tap_sum = 1'b0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_adv,
   input  logic [dw-1:0] i_add,
   output logic [dw-1:0] o_val
);

   // r_line[0] is the head, r_line[nch-1] the tail holding this slot's channel.
   logic [dw-1:0] r_line [nch];
   logic [dw-1:0] w_sum;

   // Wraps modulo 2^dw; the downstream comb cancels the wrap exactly.
   assign w_sum = r_line[nch-1] + i_add;
   assign o_val = tap_sum ? w_sum : r_line[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the delay line is state that feeds back into the adder, so
         // every entry is reset; an unreset line would integrate garbage.
         for (int k = 0; k < nch; k++) r_line[k] <= '0;
      end else if (i_adv) begin
         // NOTE: non-blocking assignments make the shift read the old
         // neighbour values; blocking here would collapse the line.
         r_line[0] <= w_sum;
         for (int k = 1; k < nch; k++) r_line[k] <= r_line[k-1];
      end
   end

endmodule

// File: rtl/cic_integ_decim.sv
// ---------------------------------------------------------------------------
// cic_integ_decim
// Time-multiplexed two-stage CIC integrator and decimation sampler for nch
// interleaved channels. Every valid slot is integrated twice; one frame in
// every `period` frames is gated out as a strobed stream for the comb stage.
//   clk       clock, all logic on posedge
//   reset_n   asynchronous active-low reset
//   bus       cic_integ_decim_if.slave: d_in/g_in/ch_first/period in,
//             d_out/g_out (and frame_err) out
// Optional feature macro: CIC_INTEG_FRAMECHK_EN adds a slot counter and the
// sticky frame_err output; without it neither exists.
// Latency: g_in at cycle t gives g_out at cycle t+2.
// ---------------------------------------------------------------------------
module cic_integ_decim
   import cic_integ_pkg::*;
#(
   parameter int dw  = dw_def,
   parameter int iw  = iw_def,
   parameter int nch = nch_def,
   parameter int pw  = pw_def
) (
   input  logic               clk,
   input  logic               reset_n,
   cic_integ_decim_if.slave   bus
);

   logic [dw-1:0] w_d_ext;
   logic [dw-1:0] w_i1_head;
   logic [dw-1:0] w_i2_new;
   logic          w_frame_start;
   logic          w_keep_now;
   logic [pw-1:0] w_reload;

   logic [pw-1:0] r_cnt;
   logic          r_keep;
   gate_t         r_gate;     // gate of the slot now in stage 2
   logic [dw-1:0] r_d_out;
   logic          r_g_out;

   assign w_d_ext       = dw'(sext(64'(bus.d_in), iw));
   assign w_frame_start = bus.g_in & bus.ch_first;
   assign w_reload      = (bus.period == '0) ? '0 : bus.period - pw'(1);

   // The frame-start slot uses the freshly decided keep; the remaining slots
   // of the frame reuse the registered decision.
   always_comb begin
      // NOTE: default assignment first so no path leaves the output unassigned
      // (that would infer a latch).
      w_keep_now = r_keep;
      if (w_frame_start) w_keep_now = (r_cnt == '0);
   end

   // Stage 1: i1[ch] += d_in, advanced on the input slot.
   integ_slot #(.dw(dw), .nch(nch), .tap_sum(1'b0)) u_stage1 (
      .clk     (clk),
      .reset_n (reset_n),
      .i_adv   (bus.g_in),
      .i_add   (w_d_ext),
      .o_val   (w_i1_head)
   );

   // Stage 2: i2[ch] += i1_head, advanced one cycle later on the delayed gate.
   integ_slot #(.dw(dw), .nch(nch), .tap_sum(1'b1)) u_stage2 (
      .clk     (clk),
      .reset_n (reset_n),
      .i_adv   (r_gate.valid),
      .i_add   (w_i1_head),
      .o_val   (w_i2_new)
   );

   // Decimation counter and gate pipeline. Reload wins over decrement, so the
   // counter never underflows; a new period is only sampled on reload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_keep <= 1'b0;
         r_gate <= '0;
      end else begin
         r_gate <= '{valid: bus.g_in, keep: w_keep_now};
         if (w_frame_start) begin
            if (r_cnt == '0) begin
               r_cnt  <= w_reload;
               r_keep <= 1'b1;
            end else begin
               r_cnt  <= r_cnt - pw'(1);
               r_keep <= 1'b0;
            end
         end
      end
   end

   // Output register: d_out only loads on emitted slots and holds otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_d_out <= '0;
         r_g_out <= 1'b0;
      end else begin
         r_g_out <= r_gate.valid & r_gate.keep;
         if (r_gate.valid & r_gate.keep) r_d_out <= w_i2_new;
      end
   end

   assign bus.d_out = r_d_out;
   assign bus.g_out = r_g_out;

`ifdef CIC_INTEG_FRAMECHK_EN
   localparam int sw = (nch > 1) ? $clog2(nch) : 1;
   localparam logic [sw-1:0] last_slot = sw'(nch - 1);

   logic [sw-1:0] r_slot;
   logic          r_frame_err;

   // Slot position within the frame; ch_first resynchronises it to 1 (the
   // slot after channel 0). Errors are sticky until reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_slot      <= '0;
         r_frame_err <= 1'b0;
      end else if (bus.g_in) begin
         if (bus.ch_first) begin
            if (r_slot != '0) r_frame_err <= 1'b1;
            r_slot <= sw'(1);
         end else begin
            if (r_slot == '0) r_frame_err <= 1'b1;
            r_slot <= (r_slot == last_slot) ? '0 : r_slot + sw'(1);
         end
      end
   end

   assign bus.frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_cic_integ_decim.sv
// ---------------------------------------------------------------------------
// tb_cic_integ_decim
// Scoreboard bench for cic_integ_decim: a per-channel behavioural model
// pushes expected {cycle, value} pairs when a slot is driven; the monitor
// pops and compares on the opposite clock edge. A 16-bit instance fed with
// the same stimulus drives a double-difference comb model for the wrap test.
// ---------------------------------------------------------------------------
module tb_cic_integ_decim;
   import cic_integ_pkg::*;

   localparam int tdw = 28;
   localparam int tiw = 18;
   localparam int tch = 4;
   localparam int tpw = 12;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   cic_integ_decim_if #(.dw(tdw), .iw(tiw), .pw(tpw)) bus ();
   cic_integ_decim_if #(.dw(16),  .iw(tiw), .pw(tpw)) bus16 ();

   cic_integ_decim #(.dw(tdw), .iw(tiw), .nch(tch), .pw(tpw)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));
   cic_integ_decim #(.dw(16), .iw(tiw), .nch(tch), .pw(tpw)) dut16 (
      .clk(clk), .reset_n(reset_n), .bus(bus16));

   assign bus16.d_in     = bus.d_in;
   assign bus16.g_in     = bus.g_in;
   assign bus16.ch_first = bus.ch_first;
   assign bus16.period   = bus.period;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      int             due;
      logic [tdw-1:0] val;
   } exp_t;

   exp_t           sb_q[$];
   logic [tdw-1:0] m_i1 [tch];
   logic [tdw-1:0] m_i2 [tch];
   logic [tpw-1:0] m_cnt;
   logic           m_keep;
   bit             sb_en = 1'b1;
   int             edge_cnt = 0;
   int             g_count = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic model_reset();
      for (int c = 0; c < tch; c++) begin
         m_i1[c] = '0;
         m_i2[c] = '0;
      end
      m_cnt  = '0;
      m_keep = 1'b0;
      sb_q.delete();
   endtask

   // Sets up one slot right after a clock edge; it is sampled at the next edge.
   task automatic drive(input bit g, input bit cf, input logic [tiw-1:0] d, input int ch);
      bus.g_in     = g;
      bus.ch_first = cf;
      bus.d_in     = d;
      if (g) begin
         if (cf) begin
            if (m_cnt == 0) begin
               m_cnt  = (bus.period == 0) ? '0 : bus.period - 1;
               m_keep = 1'b1;
            end else begin
               m_cnt  = m_cnt - 1;
               m_keep = 1'b0;
            end
         end
         m_i1[ch] = m_i1[ch] + {{(tdw-tiw){d[tiw-1]}}, d};
         m_i2[ch] = m_i2[ch] + m_i1[ch];
         if (m_keep && sb_en) sb_q.push_back('{edge_cnt + 2, m_i2[ch]});
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, '0, 0);
   endtask

   task automatic drive_frame(input logic [tiw-1:0] d);
      for (int c = 0; c < tch; c++) drive(1'b1, c == 0, d, c);
   endtask

   task automatic do_reset();
      bus.g_in     = 1'b0;
      bus.ch_first = 1'b0;
      bus.d_in     = '0;
      reset_n      = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Monitor: every cycle g_out must match whether an output is due now.
   always @(negedge clk) begin
      bit   exp_g;
      exp_t e;
      if (bus.g_out) g_count++;
      if (sb_en) begin
         exp_g = (sb_q.size() > 0) && (sb_q[0].due == edge_cnt);
         check("g_out", bus.g_out, exp_g);
         if (exp_g) begin
            e = sb_q.pop_front();
            if (bus.g_out) check("d_out", bus.d_out, e.val);
         end
      end
   end

   // Downstream double-difference comb (delay nch) on the 16-bit stream.
   logic [15:0] c_x  [tch];
   logic [15:0] c_d1 [tch];
   logic [15:0] c_y  [tch];
   int          c_cnt[tch];
   int          c_n = 0;

   always @(negedge clk) begin
      int          ch;
      logic [15:0] d1;
      if (!reset_n) begin
         c_n = 0;
         for (int c = 0; c < tch; c++) begin
            c_x[c] = '0; c_d1[c] = '0; c_y[c] = '0; c_cnt[c] = 0;
         end
      end else if (bus16.g_out) begin
         ch        = c_n % tch;
         d1        = bus16.d_out - c_x[ch];
         c_y[ch]   = d1 - c_d1[ch];
         c_x[ch]   = bus16.d_out;
         c_d1[ch]  = d1;
         c_cnt[ch] = c_cnt[ch] + 1;
         c_n       = c_n + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] wrap_full;
      logic [15:0] wrap_exp;

      bus.period = tpw'(1);
      do_reset();
      check("rst_g_out", bus.g_out, 1'b0);
      check("rst_d_out", bus.d_out, '0);
`ifdef CIC_INTEG_FRAMECHK_EN
      check("rst_frame_err", bus.frame_err, 1'b0);
`endif

      // Basic accumulation, R=1: 1, 3, 6, 10 per channel.
      repeat (4) drive_frame(18'd1);
      idle(3);

      // Decimation, R=4: frames 0, 4, 8 emitted (1, 15, 45), 4 slots each.
      bus.period = tpw'(4);
      do_reset();
      g_count = 0;
      repeat (9) drive_frame(18'd1);
      idle(3);
      check("dec_g_count", g_count, 12);

      // Random gaps, random data, period changes including 0.
      do_reset();
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) bus.period = tpw'($urandom_range(0, 3));
         for (int c = 0; c < tch; c++) begin
            repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)), 18'($urandom), 0);
            drive(1'b1, c == 0, 18'($urandom), c);
         end
      end
      idle(3);

      // Reset at slot 2 of a frame: output drops at once, restarts at frame 0.
      bus.period = tpw'(1);
      do_reset();
      drive(1'b1, 1'b1, 18'd1, 0);
      drive(1'b1, 1'b0, 18'd1, 1);
      check("mid_rst_pre_g_out", bus.g_out, 1'b1);
      bus.g_in = 1'b0;
      reset_n  = 1'b0;
      model_reset();
      #1;
      check("mid_rst_g_out", bus.g_out, 1'b0);
      check("mid_rst_d_out", bus.d_out, '0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      drive_frame(18'd1);
      idle(3);

      // Wrap with comb: dw=16 instance, x=32767, R=8 -> 32767*64 mod 2^16.
      bus.period = tpw'(8);
      do_reset();
      repeat (48) drive_frame(18'd32767);
      idle(4);
      wrap_full = 32'd32767 * 32'd64;
      wrap_exp  = wrap_full[15:0];
      for (int c = 0; c < tch; c++) begin
         check("comb_outputs", c_cnt[c] >= 3, 1'b1);
         check("comb_steady", c_y[c], wrap_exp);
      end

      check("sb_drain", sb_q.size(), 0);

`ifdef CIC_INTEG_FRAMECHK_EN
      // Short frame followed by ch_first: frame_err rises and sticks.
      sb_en = 1'b0;
      bus.period = tpw'(1);
      do_reset();
      drive(1'b1, 1'b1, 18'd1, 0);
      drive(1'b1, 1'b0, 18'd1, 1);
      drive(1'b1, 1'b0, 18'd1, 2);
      check("ferr_before", bus.frame_err, 1'b0);
      drive(1'b1, 1'b1, 18'd1, 0);
      check("ferr_rise", bus.frame_err, 1'b1);
      drive(1'b1, 1'b0, 18'd1, 1);
      drive(1'b1, 1'b0, 18'd1, 2);
      drive(1'b1, 1'b0, 18'd1, 3);
      drive_frame(18'd1);
      idle(2);
      check("ferr_sticky", bus.frame_err, 1'b1);
      do_reset();
      check("ferr_cleared", bus.frame_err, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
